// File: rtl/axi_pkg.sv
// Shared AXI3 encodings and the responder state enum for the SRAM-backed slave.
package axi_pkg;

  localparam int ID_W  = 4;
  localparam int LEN_W = 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_WRESP
  } state_e;

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI3 read/write channel bundle (no lock/cache/prot/wid) between CPU master and SRAM slave.
interface axi_sram_slave_if;
  import axi_pkg::*;

  logic [ID_W-1:0]  arid;
  logic [31:0]      araddr;
  logic [LEN_W-1:0] arlen;
  logic [2:0]       arsize;
  logic [1:0]       arburst;
  logic             arvalid;
  logic             arready;

  logic [ID_W-1:0]  rid;
  logic [31:0]      rdata;
  logic [1:0]       rresp;
  logic             rlast;
  logic             rvalid;
  logic             rready;

  logic [ID_W-1:0]  awid;
  logic [31:0]      awaddr;
  logic [LEN_W-1:0] awlen;
  logic [2:0]       awsize;
  logic [1:0]       awburst;
  logic             awvalid;
  logic             awready;

  logic [31:0]      wdata;
  logic [3:0]       wstrb;
  logic             wlast;
  logic             wvalid;
  logic             wready;

  logic [ID_W-1:0]  bid;
  logic [1:0]       bresp;
  logic             bvalid;
  logic             bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid,
    output awready, wready, bid, bresp, bvalid
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rresp, rlast, rvalid,
    input  awready, wready, bid, bresp, bvalid
  );

endinterface

// File: rtl/axi_burst_addr.sv
// Next word index of an AXI3 burst; shared by the read and write paths.
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  burst_e            burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] mask;
  logic              wrap_ok;

  always_comb begin
    incr      = addr + ADDR_W'(1);
    mask      = '0;
    mask[3:0] = len[3:0];
    wrap_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    next_addr = incr;
    // Only power-of-two WRAP lengths wrap; odd lengths and reserved bursts step like INCR.
    unique case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = wrap_ok ? ((addr & ~mask) | (incr & mask)) : incr;
      default:     next_addr = incr;
    endcase
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave over a single-port word SRAM: one burst at a time, round-robin between reads and writes.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int    ADDR_W    = 16,
  parameter string INIT_FILE = ""
) (
  input logic             aclk,
  input logic             aresetn,
  axi_sram_slave_if.slave axi
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic              rr_pref_wr_q, rr_pref_wr_d;
  logic              ar_ready, aw_ready, w_ready, b_valid;

  logic [ID_W-1:0]   rid_q, bid_q;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_next, wr_addr_q, wr_addr_next;
  logic [LEN_W-1:0]  rd_len_q, rd_cnt_q, wr_len_q, wr_cnt_q;
  burst_e            rd_burst_q, wr_burst_q;
  logic              rd_err_q, wr_err_q;
  logic [31:0]       rdata_q;
  logic              rvalid_q, rlast_q;
  logic [1:0]        rresp_q, bresp_q;

  logic              ar_hs, aw_hs, r_load, r_done, w_beat, w_at_len, wlast_bad;
  logic              unused_bits;

  axi_burst_addr #(.ADDR_W(ADDR_W)) u_rd_addr (
    .addr(rd_addr_q), .len(rd_len_q), .burst(rd_burst_q), .next_addr(rd_addr_next)
  );

  axi_burst_addr #(.ADDR_W(ADDR_W)) u_wr_addr (
    .addr(wr_addr_q), .len(wr_len_q), .burst(wr_burst_q), .next_addr(wr_addr_next)
  );

  assign ar_hs     = ar_ready && axi.arvalid;
  assign aw_hs     = aw_ready && axi.awvalid;
  // Output register loads on the first RD cycle and whenever a non-final beat is taken.
  assign r_load    = (state_q == ST_RD) && (!rvalid_q || (axi.rready && !rlast_q));
  assign r_done    = (state_q == ST_RD) && rvalid_q && axi.rready && rlast_q;
  assign w_beat    = w_ready && axi.wvalid;
  assign w_at_len  = (wr_cnt_q == wr_len_q);
  assign wlast_bad = (axi.wlast != w_at_len);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      rr_pref_wr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_pref_wr_q <= rr_pref_wr_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    rr_pref_wr_d = rr_pref_wr_q;
    ar_ready     = 1'b0;
    aw_ready     = 1'b0;
    w_ready      = 1'b0;
    b_valid      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (axi.arvalid && (!axi.awvalid || !rr_pref_wr_q)) begin
          ar_ready = 1'b1;
          state_d  = ST_RD;
          if (axi.awvalid) rr_pref_wr_d = 1'b1;
        end else if (axi.awvalid) begin
          aw_ready = 1'b1;
          state_d  = ST_WR;
          if (axi.arvalid) rr_pref_wr_d = 1'b0;
        end
      end
      ST_RD: begin
        if (r_done) state_d = ST_IDLE;
      end
      ST_WR: begin
        w_ready = 1'b1;
        if (axi.wvalid && w_at_len) state_d = ST_WRESP;
      end
      ST_WRESP: begin
        b_valid = 1'b1;
        if (axi.bready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rid_q      <= '0;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      rd_cnt_q   <= '0;
      rd_burst_q <= BURST_INCR;
      rd_err_q   <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rresp_q    <= RESP_OKAY;
    end else if (ar_hs) begin
      rid_q      <= axi.arid;
      rd_addr_q  <= axi.araddr[ADDR_W+1:2];
      rd_len_q   <= axi.arlen;
      rd_cnt_q   <= '0;
      rd_burst_q <= burst_e'(axi.arburst);
      rd_err_q   <= (axi.arburst == BURST_RSVD);
    end else if (r_load) begin
      rdata_q    <= mem[rd_addr_q];
      rvalid_q   <= 1'b1;
      rlast_q    <= (rd_cnt_q == rd_len_q);
      rresp_q    <= rd_err_q ? RESP_SLVERR : RESP_OKAY;
      rd_addr_q  <= rd_addr_next;
      rd_cnt_q   <= rd_cnt_q + 8'd1;
    end else if (r_done) begin
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bid_q      <= '0;
      wr_addr_q  <= '0;
      wr_len_q   <= '0;
      wr_cnt_q   <= '0;
      wr_burst_q <= BURST_INCR;
      wr_err_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else if (aw_hs) begin
      bid_q      <= axi.awid;
      wr_addr_q  <= axi.awaddr[ADDR_W+1:2];
      wr_len_q   <= axi.awlen;
      wr_cnt_q   <= '0;
      wr_burst_q <= burst_e'(axi.awburst);
      wr_err_q   <= (axi.awburst == BURST_RSVD);
    end else if (w_beat) begin
      wr_addr_q  <= wr_addr_next;
      wr_cnt_q   <= wr_cnt_q + 8'd1;
      if (wlast_bad) wr_err_q <= 1'b1;
      if (w_at_len) bresp_q <= (wr_err_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // NOTE: the SRAM array has no reset; contents survive aresetn like a real RAM.
  always_ff @(posedge aclk) begin
    if (w_beat) begin
      for (int b = 0; b < 4; b++) begin
        if (axi.wstrb[b]) mem[wr_addr_q][8*b +: 8] <= axi.wdata[8*b +: 8];
      end
    end
  end

  assign axi.arready = ar_ready;
  assign axi.awready = aw_ready;
  assign axi.wready  = w_ready;
  assign axi.bvalid  = b_valid;
  assign axi.bid     = bid_q;
  assign axi.bresp   = bresp_q;
  assign axi.rid     = rid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign axi.rlast   = rlast_q;
  assign axi.rvalid  = rvalid_q;

  // Size and the sub-word / above-array address bits do not affect a 32-bit word SRAM.
  assign unused_bits = ^{axi.arsize, axi.awsize, axi.araddr[1:0], axi.awaddr[1:0],
                         axi.araddr[31:ADDR_W+2], axi.awaddr[31:ADDR_W+2]};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: single-beat vector table plus burst, stall and arbitration sequences.
module tb_axi_sram_slave;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;
  localparam logic [1:0] RSVD  = 2'b11;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  axi_sram_slave_if axi();

  axi_sram_slave #(.ADDR_W(16), .INIT_FILE("")) dut (
    .aclk(aclk), .aresetn(aresetn), .axi(axi)
  );

  always #5 aclk = ~aclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    bit          is_wr;
    logic [31:0] addr;
    logic [1:0]  burst;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  localparam int NV = 11;
  vec_t vec [NV];

  logic [31:0] wbuf_data [16];
  logic [3:0]  wbuf_strb [16];
  logic        wbuf_last [16];
  logic [31:0] rbuf_data [16];
  logic        rbuf_last [16];
  logic [1:0]  rbuf_resp [16];
  logic [3:0]  rbuf_id   [16];
  int          rbuf_cyc  [16];
  int          rcount;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n = 0;
    axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = 3'd2;
    axi.arburst = burst; axi.arvalid = 1'b1;
    @(negedge aclk);
    while (!axi.arready && n < 20) begin n++; @(negedge aclk); end
    check("ar_accept", {31'b0, axi.arready}, 32'd1);
    tick();
    axi.arvalid = 1'b0;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n = 0;
    axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = 3'd2;
    axi.awburst = burst; axi.awvalid = 1'b1;
    @(negedge aclk);
    while (!axi.awready && n < 20) begin n++; @(negedge aclk); end
    check("aw_accept", {31'b0, axi.awready}, 32'd1);
    tick();
    axi.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    axi.wdata = data; axi.wstrb = strb; axi.wlast = last; axi.wvalid = 1'b1;
    @(negedge aclk);
    while (!axi.wready && n < 20) begin n++; @(negedge aclk); end
    check("w_accept", {31'b0, axi.wready}, 32'd1);
    tick();
    axi.wvalid = 1'b0;
  endtask

  task automatic recv_b();
    int n = 0;
    axi.bready = 1'b1;
    @(negedge aclk);
    while (!axi.bvalid && n < 20) begin n++; @(negedge aclk); end
    check("b_valid", {31'b0, axi.bvalid}, 32'd1);
    b_resp = axi.bresp;
    b_id   = axi.bid;
    tick();
    axi.bready = 1'b0;
  endtask

  task automatic recv_r(input int n);
    int cyc = 0;
    rcount = 0;
    axi.rready = 1'b1;
    while (rcount < n && cyc < 100) begin
      @(negedge aclk);
      if (axi.rvalid) begin
        rbuf_data[rcount] = axi.rdata;
        rbuf_last[rcount] = axi.rlast;
        rbuf_resp[rcount] = axi.rresp;
        rbuf_id[rcount]   = axi.rid;
        rbuf_cyc[rcount]  = cyc;
        rcount++;
      end
      cyc++;
    end
    check("r_beat_count", rcount, n);
    tick();
    axi.rready = 1'b0;
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [1:0] burst);
    send_aw(id, addr, len, burst);
    for (int i = 0; i <= int'(len); i++) send_w(wbuf_data[i], wbuf_strb[i], wbuf_last[i]);
    recv_b();
  endtask

  initial begin
    axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0;
    axi.arvalid = 1'b0; axi.rready = 1'b0;
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
    axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0;
    axi.wvalid = 1'b0; axi.bready = 1'b0;

    vec[0]  = '{"w_full",    1'b1, 32'h44,      INCR, 32'h11223344, 4'hF, 32'h0,        2'b00};
    vec[1]  = '{"r_full",    1'b0, 32'h44,      INCR, 32'h0,        4'h0, 32'h11223344, 2'b00};
    vec[2]  = '{"w_strb5",   1'b1, 32'h44,      INCR, 32'hAABBCCDD, 4'h5, 32'h0,        2'b00};
    vec[3]  = '{"r_strb5",   1'b0, 32'h44,      INCR, 32'h0,        4'h0, 32'h11BB33DD, 2'b00};
    vec[4]  = '{"w_unalign", 1'b1, 32'h47,      FIXED, 32'h55667788, 4'hF, 32'h0,       2'b00};
    vec[5]  = '{"r_unalign", 1'b0, 32'h44,      INCR, 32'h0,        4'h0, 32'h55667788, 2'b00};
    vec[6]  = '{"w_alias",   1'b1, 32'h00040048, INCR, 32'hCAFEF00D, 4'hF, 32'h0,       2'b00};
    vec[7]  = '{"r_alias",   1'b0, 32'h48,      INCR, 32'h0,        4'h0, 32'hCAFEF00D, 2'b00};
    vec[8]  = '{"w_rsvd",    1'b1, 32'h4C,      RSVD, 32'h01020304, 4'hF, 32'h0,        2'b10};
    vec[9]  = '{"r_rsvd",    1'b0, 32'h4C,      RSVD, 32'h0,        4'h0, 32'h01020304, 2'b10};
    vec[10] = '{"w_nostrb",  1'b1, 32'h4C,      INCR, 32'hFFFFFFFF, 4'h0, 32'h0,        2'b00};

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check("rst_arready", {31'b0, axi.arready}, 32'd0);
    check("rst_awready", {31'b0, axi.awready}, 32'd0);
    check("rst_wready",  {31'b0, axi.wready},  32'd0);
    check("rst_rvalid",  {31'b0, axi.rvalid},  32'd0);
    check("rst_rlast",   {31'b0, axi.rlast},   32'd0);
    check("rst_bvalid",  {31'b0, axi.bvalid},  32'd0);
    check("rst_rdata",   axi.rdata, 32'd0);
    check("rst_ids",     {24'b0, axi.rid, axi.bid}, 32'd0);
    check("rst_resps",   {28'b0, axi.rresp, axi.bresp}, 32'd0);
    aresetn = 1'b1;
    tick();

    // Single-beat vector table
    for (int i = 0; i < NV; i++) begin
      if (vec[i].is_wr) begin
        send_aw(i[3:0], vec[i].addr, 8'd0, vec[i].burst);
        send_w(vec[i].wdata, vec[i].wstrb, 1'b1);
        recv_b();
        check({vec[i].name, "_bresp"}, {30'b0, b_resp}, {30'b0, vec[i].exp_resp});
        check({vec[i].name, "_bid"}, {28'b0, b_id}, i);
      end else begin
        send_ar(i[3:0], vec[i].addr, 8'd0, vec[i].burst);
        recv_r(1);
        check({vec[i].name, "_rdata"}, rbuf_data[0], vec[i].exp_data);
        check({vec[i].name, "_rresp"}, {30'b0, rbuf_resp[0]}, {30'b0, vec[i].exp_resp});
        check({vec[i].name, "_rlast"}, {31'b0, rbuf_last[0]}, 32'd1);
        check({vec[i].name, "_rid"}, {28'b0, rbuf_id[0]}, i);
      end
    end
    send_ar(4'd0, 32'h4C, 8'd0, INCR);
    recv_r(1);
    check("r_nostrb_rdata", rbuf_data[0], 32'h01020304);

    // Single read latency: handshake cycle T, beat 0 at T+2
    wbuf_data[0] = 32'hDEADBEEF; wbuf_strb[0] = 4'hF; wbuf_last[0] = 1'b1;
    write_burst(4'd9, 32'h40, 8'd0, INCR);
    send_ar(4'd3, 32'h40, 8'd0, INCR);
    check("lat_t1_rvalid", {31'b0, axi.rvalid}, 32'd0);
    axi.rready = 1'b1;
    tick();
    check("lat_t2_rvalid", {31'b0, axi.rvalid}, 32'd1);
    check("lat_t2_rdata",  axi.rdata, 32'hDEADBEEF);
    check("lat_t2_rlast",  {31'b0, axi.rlast}, 32'd1);
    check("lat_t2_rid",    {28'b0, axi.rid}, 32'd3);
    check("lat_t2_rresp",  {30'b0, axi.rresp}, 32'd0);
    tick();
    check("lat_rvalid_drop", {31'b0, axi.rvalid}, 32'd0);
    axi.rready = 1'b0;

    // Fill words 0..7, then an 8-beat WRAP read from 0x18
    for (int i = 0; i < 8; i++) begin
      wbuf_data[i] = 32'hA0000000 | i; wbuf_strb[i] = 4'hF; wbuf_last[i] = (i == 7);
    end
    write_burst(4'd1, 32'h0, 8'd7, INCR);
    check("fill_bresp", {30'b0, b_resp}, 32'd0);
    send_ar(4'd2, 32'h18, 8'd7, WRAP);
    recv_r(8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("wrap_data%0d", i), rbuf_data[i], 32'hA0000000 | ((6 + i) % 8));
      check($sformatf("wrap_last%0d", i), {31'b0, rbuf_last[i]}, (i == 7) ? 32'd1 : 32'd0);
      if (i > 0) check($sformatf("wrap_gap%0d", i), rbuf_cyc[i] - rbuf_cyc[i-1], 32'd1);
    end

    // INCR len=3 read with rready pattern 1,0,0,1
    begin
      int          cnt = 0;
      bit          stalled = 1'b0;
      logic [31:0] held = '0;
      logic        pat [4];
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      send_ar(4'd4, 32'h0, 8'd3, INCR);
      for (int c = 0; c < 60 && cnt < 4; c++) begin
        axi.rready = pat[c % 4];
        @(negedge aclk);
        if (axi.rvalid) begin
          if (stalled) check("stall_hold", axi.rdata, held);
          if (axi.rready) begin
            rbuf_data[cnt] = axi.rdata; rbuf_last[cnt] = axi.rlast; cnt++; stalled = 1'b0;
          end else begin
            stalled = 1'b1; held = axi.rdata;
          end
        end
        tick();
      end
      axi.rready = 1'b0;
      check("stall_beats", cnt, 32'd4);
      for (int i = 0; i < 4; i++) check($sformatf("stall_data%0d", i), rbuf_data[i], 32'hA0000000 | i);
      check("stall_last", {31'b0, rbuf_last[3]}, 32'd1);
    end

    // Write len=3 INCR at 0x100 with wstrb=0011 on beat 1
    wbuf_data[0] = 32'h12345678; wbuf_strb[0] = 4'hF; wbuf_last[0] = 1'b1;
    write_burst(4'd6, 32'h104, 8'd0, INCR);
    for (int i = 0; i < 4; i++) begin
      wbuf_data[i] = 32'hB0000000 | i; wbuf_strb[i] = 4'hF; wbuf_last[i] = (i == 3);
    end
    wbuf_data[1] = 32'h9999AAAA; wbuf_strb[1] = 4'b0011;
    write_burst(4'd5, 32'h100, 8'd3, INCR);
    check("wstrb_bresp", {30'b0, b_resp}, 32'd0);
    check("wstrb_bid",   {28'b0, b_id}, 32'd5);
    send_ar(4'd5, 32'h100, 8'd3, INCR);
    recv_r(4);
    check("wstrb_rd0", rbuf_data[0], 32'hB0000000);
    check("wstrb_rd1", rbuf_data[1], 32'h1234AAAA);
    check("wstrb_rd2", rbuf_data[2], 32'hB0000002);
    check("wstrb_rd3", rbuf_data[3], 32'hB0000003);

    // Write len=1 with wlast early on beat 0
    wbuf_data[0] = 32'h11111111; wbuf_strb[0] = 4'hF; wbuf_last[0] = 1'b1;
    wbuf_data[1] = 32'h22222222; wbuf_strb[1] = 4'hF; wbuf_last[1] = 1'b0;
    write_burst(4'd7, 32'h200, 8'd1, INCR);
    check("wlast_bresp", {30'b0, b_resp}, 32'd2);
    check("wlast_bid",   {28'b0, b_id}, 32'd7);
    send_ar(4'd7, 32'h200, 8'd1, INCR);
    recv_r(2);
    check("wlast_rd0", rbuf_data[0], 32'h11111111);
    check("wlast_rd1", rbuf_data[1], 32'h22222222);

    // arvalid and awvalid held together: grants alternate R, W, R
    begin
      int         grants = 0;
      int         both = 0;
      logic [2:0] order = '0;
      axi.arid = 4'd1; axi.araddr = 32'h0; axi.arlen = 8'd0; axi.arburst = INCR; axi.arvalid = 1'b1;
      axi.awid = 4'd2; axi.awaddr = 32'h300; axi.awlen = 8'd0; axi.awburst = INCR; axi.awvalid = 1'b1;
      axi.wdata = 32'h5A5A5A5A; axi.wstrb = 4'hF; axi.wlast = 1'b1; axi.wvalid = 1'b1;
      axi.bready = 1'b1; axi.rready = 1'b1;
      for (int c = 0; c < 80 && grants < 3; c++) begin
        @(negedge aclk);
        if (axi.arready && axi.awready) both++;
        if (axi.arready) begin order = {order[1:0], 1'b0}; grants++; end
        else if (axi.awready) begin order = {order[1:0], 1'b1}; grants++; end
        tick();
      end
      axi.arvalid = 1'b0; axi.awvalid = 1'b0;
      repeat (10) tick();
      axi.wvalid = 1'b0; axi.bready = 1'b0; axi.rready = 1'b0;
      check("arb_grants", grants, 32'd3);
      check("arb_order",  {29'b0, order}, 32'b010);
      check("arb_both_ready", both, 32'd0);
      send_ar(4'd8, 32'h300, 8'd0, INCR);
      recv_r(1);
      check("arb_wdata", rbuf_data[0], 32'h5A5A5A5A);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
